// File: rtl/snake_engine.sv
// -----------------------------------------------------------------------------
// snake_engine
// Snake movement engine for the VGA snake game. Holds up to MAX_LEN segment
// coordinates on a GRID_W x GRID_H cell grid and advances the snake by one
// cell every tick_period clocks while run is high. Direction requests go
// through a 2-deep queue. Growth requests are counted and applied on later
// moves. Wall and self collisions set a sticky dead flag. Wrap mode instead
// passes the head through the border. A registered per-cell query port
// classifies the cell currently being rendered.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             pulse: reload the initial snake (same effect as reset)
//   run               level: stepping enabled
//   tick_period       clocks per step (0 behaves as 1)
//   wrap_mode         1 = wrap through border, 0 = border is lethal
//   dir_valid/dir_req direction request (00 UP, 01 DOWN, 10 LEFT, 11 RIGHT)
//   grow              pulse: add one segment on a later move
//   query_x/query_y   cell being rendered
//   query_hit         00 none, 01 head, 10 body, 11 wall (1-cycle latency)
//   head_x/head_y     head cell
//   length            current segment count
//   step              one-cycle pulse after each move decision
//   dead, dead_cause  sticky collision flag, cause 01 wall / 10 body
// -----------------------------------------------------------------------------
module snake_engine #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int CW       = 6,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 5,
    parameter int INIT_X   = 10,
    parameter int INIT_Y   = 5,
    parameter int TICK_W   = 24
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         run,
    input  logic [TICK_W-1:0]            tick_period,
    input  logic                         wrap_mode,
    input  logic                         dir_valid,
    input  logic [1:0]                   dir_req,
    input  logic                         grow,
    input  logic [CW-1:0]                query_x,
    input  logic [CW-1:0]                query_y,
    output logic [1:0]                   query_hit,
    output logic [CW-1:0]                head_x,
    output logic [CW-1:0]                head_y,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic                         step,
    output logic                         dead,
    output logic [1:0]                   dead_cause
);

    localparam int              LW       = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0]   C_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]   C_ONE    = CW'(1);
    localparam logic [CW-1:0]   X_LAST   = CW'(GRID_W - 1);
    localparam logic [CW-1:0]   Y_LAST   = CW'(GRID_H - 1);
    localparam logic [CW-1:0]   X_WRAP   = CW'(GRID_W - 2);
    localparam logic [CW-1:0]   Y_WRAP   = CW'(GRID_H - 2);
    localparam logic [LW-1:0]   LEN_MAX  = LW'(MAX_LEN);
    localparam logic [LW-1:0]   LEN_INIT = LW'(INIT_LEN);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // UP/DOWN and LEFT/RIGHT differ only in bit 0
    function automatic dir_t opposite(input dir_t d);
        opposite = dir_t'({d[1], ~d[0]});
    endfunction

    function automatic logic on_border(input logic [CW-1:0] x, input logic [CW-1:0] y);
        on_border = (x == C_ZERO) || (x == X_LAST) || (y == C_ZERO) || (y == Y_LAST);
    endfunction

    function automatic logic [CW-1:0] init_x(input int i);
        if (i < INIT_LEN) init_x = CW'(INIT_X - i);
        else              init_x = C_ZERO;
    endfunction

    function automatic logic [CW-1:0] init_y(input int i);
        if (i < INIT_LEN) init_y = CW'(INIT_Y);
        else              init_y = C_ZERO;
    endfunction

    logic [CW-1:0]     seg_x_r [MAX_LEN];
    logic [CW-1:0]     seg_y_r [MAX_LEN];
    logic [LW-1:0]     len_r;
    logic [LW-1:0]     pend_r;
    dir_t              dir_r;
    dir_t              q_r [2];
    logic [1:0]        q_cnt_r;
    logic [TICK_W-1:0] cnt_r;
    logic              dead_r;
    logic              step_r;
    logic [1:0]        cause_r;
    logic [1:0]        qhit_r;

    logic [TICK_W-1:0] tp_last_s;
    logic              tick_s;
    dir_t              mv_dir_s;
    logic [CW-1:0]     raw_x_s, raw_y_s, nxt_x_s, nxt_y_s;
    logic              wall_s, grow_apply_s, body_hit_s, move_ok_s, pend_dec_s, grow_acc_s;
    logic [LW-1:0]     chk_lim_s;
    dir_t              q_pop_s [2];
    logic [1:0]        q_pop_cnt_s;
    dir_t              cur_pop_s;
    dir_t              ref_s;
    logic              enq_s;
    dir_t              q_nxt_s [2];
    logic [1:0]        q_nxt_cnt_s;
    logic              qbody_s;
    logic [1:0]        qhit_s;

    // terminal count of the step counter; period 0 behaves as period 1
    always_comb begin
        if (tick_period == {TICK_W{1'b0}}) tp_last_s = {TICK_W{1'b0}};
        else                               tp_last_s = tick_period - TICK_W'(1);
        tick_s = run & ~dead_r & (cnt_r == tp_last_s);
    end

    // next head cell from the direction that becomes current at this move
    always_comb begin
        if (q_cnt_r != 2'd0) mv_dir_s = q_r[0];
        else                 mv_dir_s = dir_r;
        raw_x_s = seg_x_r[0];
        raw_y_s = seg_y_r[0];
        case (mv_dir_s)
            DIR_UP:    raw_y_s = seg_y_r[0] - C_ONE;
            DIR_DOWN:  raw_y_s = seg_y_r[0] + C_ONE;
            DIR_LEFT:  raw_x_s = seg_x_r[0] - C_ONE;
            DIR_RIGHT: raw_x_s = seg_x_r[0] + C_ONE;
            default:   raw_x_s = seg_x_r[0];
        endcase
        nxt_x_s = raw_x_s;
        nxt_y_s = raw_y_s;
        if (wrap_mode) begin
            // entering a border cell re-enters on the opposite interior edge
            if (raw_x_s == C_ZERO)      nxt_x_s = X_WRAP;
            else if (raw_x_s == X_LAST) nxt_x_s = C_ONE;
            else                        nxt_x_s = raw_x_s;
            if (raw_y_s == C_ZERO)      nxt_y_s = Y_WRAP;
            else if (raw_y_s == Y_LAST) nxt_y_s = C_ONE;
            else                        nxt_y_s = raw_y_s;
        end else begin
            nxt_x_s = raw_x_s;
            nxt_y_s = raw_y_s;
        end
        wall_s = ~wrap_mode & on_border(raw_x_s, raw_y_s);
    end

    // self collision; the tail cell is free unless growth keeps it in place
    always_comb begin
        grow_apply_s = (pend_r != LW'(0)) && (len_r < LEN_MAX);
        if (grow_apply_s) chk_lim_s = len_r;
        else              chk_lim_s = len_r - LW'(1);
        body_hit_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < chk_lim_s) && (seg_x_r[i] == nxt_x_s) && (seg_y_r[i] == nxt_y_s))
                body_hit_s = 1'b1;
            else
                body_hit_s = body_hit_s;
        end
        move_ok_s  = ~wall_s & ~body_hit_s;
        pend_dec_s = tick_s & move_ok_s & grow_apply_s;
        grow_acc_s = grow && ((len_r + pend_r) < LEN_MAX);
    end

    // direction queue: pop at a move first, then filter and push the request
    always_comb begin
        q_pop_s[0]  = q_r[0];
        q_pop_s[1]  = q_r[1];
        q_pop_cnt_s = q_cnt_r;
        cur_pop_s   = dir_r;
        if (tick_s && (q_cnt_r != 2'd0)) begin
            cur_pop_s   = mv_dir_s;
            q_pop_s[0]  = q_r[1];
            q_pop_cnt_s = q_cnt_r - 2'd1;
        end else begin
            cur_pop_s   = dir_r;
        end
        case (q_pop_cnt_s)
            2'd0:    ref_s = cur_pop_s;
            2'd1:    ref_s = q_pop_s[0];
            default: ref_s = q_pop_s[1];
        endcase
        enq_s = dir_valid && (q_pop_cnt_s < 2'd2) &&
                (dir_req != ref_s) && (dir_req != opposite(ref_s));
        q_nxt_s[0]  = q_pop_s[0];
        q_nxt_s[1]  = q_pop_s[1];
        q_nxt_cnt_s = q_pop_cnt_s;
        if (enq_s) begin
            if (q_pop_cnt_s == 2'd0) q_nxt_s[0] = dir_t'(dir_req);
            else                     q_nxt_s[1] = dir_t'(dir_req);
            q_nxt_cnt_s = q_pop_cnt_s + 2'd1;
        end else begin
            q_nxt_cnt_s = q_pop_cnt_s;
        end
    end

    // renderer query classification against the current snake
    always_comb begin
        qbody_s = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_r) && (seg_x_r[i] == query_x) && (seg_y_r[i] == query_y))
                qbody_s = 1'b1;
            else
                qbody_s = qbody_s;
        end
        if (on_border(query_x, query_y))                            qhit_s = 2'b11;
        else if ((query_x == seg_x_r[0]) && (query_y == seg_y_r[0])) qhit_s = 2'b01;
        else if (qbody_s)                                            qhit_s = 2'b10;
        else                                                         qhit_s = 2'b00;
    end

    // game state registers; start reloads exactly what reset loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= init_x(i);
                seg_y_r[i] <= init_y(i);
            end
            len_r <= LEN_INIT;  pend_r <= LW'(0);  dir_r <= DIR_RIGHT;
            q_r[0] <= DIR_UP;   q_r[1] <= DIR_UP;  q_cnt_r <= 2'd0;
            cnt_r <= {TICK_W{1'b0}};  dead_r <= 1'b0;  cause_r <= 2'b00;
            step_r <= 1'b0;     qhit_r <= 2'b00;
        end else if (start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= init_x(i);
                seg_y_r[i] <= init_y(i);
            end
            len_r <= LEN_INIT;  pend_r <= LW'(0);  dir_r <= DIR_RIGHT;
            q_r[0] <= DIR_UP;   q_r[1] <= DIR_UP;  q_cnt_r <= 2'd0;
            cnt_r <= {TICK_W{1'b0}};  dead_r <= 1'b0;  cause_r <= 2'b00;
            step_r <= 1'b0;     qhit_r <= 2'b00;
        end else begin
            if (run && !dead_r) begin
                if (tick_s) cnt_r <= {TICK_W{1'b0}};
                else        cnt_r <= cnt_r + TICK_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            step_r  <= tick_s;
            qhit_r  <= qhit_s;
            dir_r   <= cur_pop_s;
            q_r[0]  <= q_nxt_s[0];
            q_r[1]  <= q_nxt_s[1];
            q_cnt_r <= q_nxt_cnt_s;
            pend_r  <= pend_r - LW'(pend_dec_s) + LW'(grow_acc_s);
            if (tick_s && move_ok_s) begin
                // shifting every slot lets a new tail inherit the old tail cell
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_r[i] <= seg_x_r[i-1];
                    seg_y_r[i] <= seg_y_r[i-1];
                end
                seg_x_r[0] <= nxt_x_s;
                seg_y_r[0] <= nxt_y_s;
                if (grow_apply_s) len_r <= len_r + LW'(1);
                else              len_r <= len_r;
            end else if (tick_s) begin
                dead_r  <= 1'b1;
                cause_r <= wall_s ? 2'b01 : 2'b10;
            end else begin
                dead_r  <= dead_r;
            end
        end
    end

    assign head_x     = seg_x_r[0];
    assign head_y     = seg_y_r[0];
    assign length     = len_r;
    assign step       = step_r;
    assign dead       = dead_r;
    assign dead_cause = cause_r;
    assign query_hit  = qhit_r;

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int ML = 16;

    logic        clk = 1'b0;
    logic        rst_n, start, run, wrap_mode, dir_valid, grow;
    logic [23:0] tick_period;
    logic [1:0]  dir_req;
    logic [5:0]  query_x, query_y;
    logic [1:0]  query_hit, dead_cause;
    logic [5:0]  head_x, head_y;
    logic [4:0]  length;
    logic        step, dead;

    int n_checks = 0;
    int n_fail   = 0;

    snake_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .run(run),
        .tick_period(tick_period), .wrap_mode(wrap_mode),
        .dir_valid(dir_valid), .dir_req(dir_req), .grow(grow),
        .query_x(query_x), .query_y(query_y), .query_hit(query_hit),
        .head_x(head_x), .head_y(head_y), .length(length),
        .step(step), .dead(dead), .dead_cause(dead_cause)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (snake as a queue of cells) ----------
    int mx[$];
    int my[$];
    int mq[$];
    int mdir, mpend, mcause, mcnt, mqhit;
    bit mdead, mstep;

    task automatic m_init();
        mx.delete(); my.delete(); mq.delete();
        for (int i = 0; i < 5; i++) begin
            mx.push_back(10 - i);
            my.push_back(5);
        end
        mdir = 3; mpend = 0; mcause = 0; mcnt = 0; mqhit = 0;
        mdead = 0; mstep = 0;
    endtask

    function automatic int m_classify(int qx, int qy);
        if (qx == 0 || qx == GW - 1 || qy == 0 || qy == GH - 1) return 3;
        if (qx == mx[0] && qy == my[0]) return 1;
        for (int i = 1; i < mx.size(); i++)
            if (mx[i] == qx && my[i] == qy) return 2;
        return 0;
    endfunction

    function automatic int opp(int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic m_step();
        int tp, nx, ny, lim, refd;
        bit tick, ga, gacc, hit;
        if (start) begin
            m_init();
            return;
        end
        mqhit = m_classify(int'(query_x), int'(query_y));
        tp    = (tick_period == 0) ? 1 : int'(tick_period);
        tick  = run && !mdead && (mcnt == tp - 1);
        if (run && !mdead) mcnt = tick ? 0 : mcnt + 1;
        mstep = tick;
        ga    = (mpend > 0) && (mx.size() < ML);
        gacc  = grow && (mx.size() + mpend < ML);
        if (tick) begin
            if (mq.size() > 0) mdir = mq.pop_front();
            nx = mx[0]; ny = my[0];
            case (mdir)
                0: ny = ny - 1;
                1: ny = ny + 1;
                2: nx = nx - 1;
                default: nx = nx + 1;
            endcase
            if (!wrap_mode && (nx == 0 || nx == GW - 1 || ny == 0 || ny == GH - 1)) begin
                mdead = 1; mcause = 1;
            end else begin
                if (nx == 0) nx = GW - 2; else if (nx == GW - 1) nx = 1;
                if (ny == 0) ny = GH - 2; else if (ny == GH - 1) ny = 1;
                lim = ga ? mx.size() : mx.size() - 1;
                hit = 0;
                for (int i = 1; i < lim; i++)
                    if (mx[i] == nx && my[i] == ny) hit = 1;
                if (hit) begin
                    mdead = 1; mcause = 2;
                end else begin
                    mx.push_front(nx); my.push_front(ny);
                    if (ga) mpend--;
                    else begin
                        void'(mx.pop_back()); void'(my.pop_back());
                    end
                end
            end
        end
        if (dir_valid) begin
            refd = (mq.size() > 0) ? mq[mq.size() - 1] : mdir;
            if (mq.size() < 2 && int'(dir_req) != refd && int'(dir_req) != opp(refd))
                mq.push_back(int'(dir_req));
        end
        if (gacc) mpend++;
    endtask

    // ---------------- checking helpers ---------------------------------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [22:0] act, exp;
        act = {query_hit, head_x, head_y, length, step, dead, dead_cause};
        exp = {2'(mqhit), 6'(mx[0]), 6'(my[0]), 5'(mx.size()), mstep, mdead, 2'(mcause)};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model t=%0t: qhit/hx/hy/len/step/dead/cause got %0d/%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                     $time, query_hit, head_x, head_y, length, step, dead, dead_cause,
                     mqhit, mx[0], my[0], mx.size(), mstep, mdead, mcause);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_step(string name);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (step !== 1'b1 && k < 40);
        check(name, 32'(step), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_dir(int d);
        dir_valid = 1'b1;
        dir_req   = 2'(d);
        cyc();
        dir_valid = 1'b0;
    endtask

    typedef struct {
        int qx;
        int qy;
        int exp;
    } qvec_t;

    qvec_t qv[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; run = 1'b0; wrap_mode = 1'b0;
        dir_valid = 1'b0; dir_req = 2'd0; grow = 1'b0;
        tick_period = 24'd4; query_x = 6'd20; query_y = 6'd20;
        m_init();
        repeat (2) @(negedge clk);
        check("reset_head_x", 32'(head_x), 32'd10);
        check("reset_head_y", 32'(head_y), 32'd5);
        check("reset_length", 32'(length), 32'd5);
        check("reset_flags",  32'({step, dead, dead_cause, query_hit}), 32'd0);
        rst_n = 1'b1;

        // query table against the initial snake (run=0, snake static)
        qv[0] = '{0, 7, 3};   qv[1] = '{10, 5, 1}; qv[2] = '{9, 5, 2};
        qv[3] = '{20, 20, 0}; qv[4] = '{39, 12, 3}; qv[5] = '{6, 5, 2};
        qv[6] = '{5, 5, 0};   qv[7] = '{15, 29, 3};
        for (int i = 0; i < 8; i++) begin
            query_x = 6'(qv[i].qx);
            query_y = 6'(qv[i].qy);
            cyc();
            check("query_table", 32'(query_hit), 32'(qv[i].exp));
        end
        query_x = 6'd20; query_y = 6'd20;

        // step every 4 clocks, head advancing right
        run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check("step_period4", 32'(step), (k % 4 == 0) ? 32'd1 : 32'd0);
            if (k == 4) check("head_after_1", 32'({head_x, head_y}), 32'({6'd11, 6'd5}));
            if (k == 8) check("head_after_2", 32'({head_x, head_y}), 32'({6'd12, 6'd5}));
        end
        check("len_after_moves", 32'(length), 32'd5);

        // direction queue: LEFT (reversal) dropped, UP kept, DOWN dropped
        tick_period = 24'd8;
        pulse_start();
        send_dir(2); send_dir(0); send_dir(1);
        wait_step("dirq_step1");
        check("dirq_head1", 32'({head_x, head_y}), 32'({6'd10, 6'd4}));
        wait_step("dirq_step2");
        check("dirq_head2", 32'({head_x, head_y}), 32'({6'd10, 6'd3}));

        // wall death with wrap off, period 0 means every clock
        tick_period = 24'd0; wrap_mode = 1'b0;
        pulse_start();
        repeat (28) cyc();
        check("wall_pre_x", 32'(head_x), 32'd38);
        cyc();
        check("wall_dead", 32'({step, dead, dead_cause}), 32'({1'b1, 1'b1, 2'b01}));
        check("wall_head_x", 32'(head_x), 32'd38);
        repeat (3) cyc();
        check("wall_sticky", 32'({step, dead}), 32'({1'b0, 1'b1}));

        // wrap through the right border
        wrap_mode = 1'b1;
        pulse_start();
        repeat (29) cyc();
        check("wrap_head", 32'({head_x, head_y, dead}), 32'({6'd1, 6'd5, 1'b0}));

        // growth up to the length limit
        tick_period = 24'd4;
        for (int g = 0; g < 9; g++) begin
            grow = 1'b1; cyc(); grow = 1'b0;
            wait_step("grow_step");
        end
        check("grow_len14", 32'(length), 32'd14);
        grow = 1'b1; repeat (3) cyc(); grow = 1'b0;
        wait_step("grow_s15"); check("grow_len15", 32'(length), 32'd15);
        wait_step("grow_s16"); check("grow_len16", 32'(length), 32'd16);
        wait_step("grow_sat"); check("grow_len_sat", 32'(length), 32'd16);

        // asynchronous reset away from any clock edge
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_head", 32'({head_x, head_y}), 32'({6'd10, 6'd5}));
        check("async_rst_misc", 32'({length, step, dead, dead_cause, query_hit}),
              32'({5'd5, 1'b0, 1'b0, 2'b00, 2'b00}));
        @(negedge clk);
        rst_n = 1'b1;
        m_init();

        // self collision: DOWN, LEFT, UP
        wrap_mode = 1'b0;
        pulse_start();
        send_dir(1); wait_step("self_s1");
        send_dir(2); wait_step("self_s2");
        send_dir(0); wait_step("self_s3");
        check("self_dead", 32'({dead, dead_cause}), 32'({1'b1, 2'b10}));
        check("self_head", 32'({head_x, head_y}), 32'({6'd9, 6'd6}));
        pulse_start();
        check("start_clears", 32'({head_x, head_y, length, dead, dead_cause}),
              32'({6'd10, 6'd5, 5'd5, 1'b0, 2'b00}));

        // randomized play against the model
        for (int k = 0; k < 3000; k++) begin
            run       = ($urandom_range(0, 9) != 0);
            dir_valid = ($urandom_range(0, 2) == 0);
            dir_req   = 2'($urandom_range(0, 3));
            grow      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) wrap_mode = ~wrap_mode;
            start = mdead ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
            if (start) tick_period = 24'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                int s;
                s = $urandom_range(0, mx.size() - 1);
                query_x = 6'(mx[s]);
                query_y = 6'(my[s]);
            end else begin
                query_x = 6'($urandom_range(0, 41));
                query_y = 6'($urandom_range(0, 31));
            end
            cyc();
        end
        start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake-movement engine for the VGA snake game: holds up to MAX_LEN segment coordinates on a GRID_W×GRID_H cell grid and advances the snake one cell per programmable tick. It buffers direction requests in a 2-deep queue, applies growth, detects wall and self collisions, and optionally wraps at the border. A registered per-cell query port feeds the pixel renderer. Sits between the key/game-status logic and the VGA colour mux.

## Interface
- GRID_W, 40, grid width in cells; border columns 0 and GRID_W-1.
- GRID_H, 30, grid height in cells; border rows 0 and GRID_H-1.
- CW, 6, coordinate width; must satisfy 2^CW ≥ max(GRID_W, GRID_H).
- MAX_LEN, 16, maximum segment count (≥ INIT_LEN).
- INIT_LEN, 5, segment count after reset/start.
- INIT_X, 10 / INIT_Y, 5, initial head cell; requires INIT_X-INIT_LEN+1 ≥ 1.
- TICK_W, 24, width of step-period counter.
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: reload initial snake, clear dead/queue/growth.
- run  in  1  level: stepping enabled (PLAY state).
- tick_period  in  TICK_W  clocks per step; 0 treated as 1.
- wrap_mode  in  1  1 = wrap through border, 0 = border is lethal.
- dir_valid  in  1  direction request strobe.
- dir_req  in  2  00 UP, 01 DOWN, 10 LEFT, 11 RIGHT.
- grow  in  1  pulse: add one segment.
- query_x / query_y  in  CW  cell being rendered.
- query_hit  out  2  00 none, 01 head, 10 body, 11 wall.
- head_x / head_y  out  CW  head cell.
- length  out  $clog2(MAX_LEN+1)  current segment count.
- step  out  1  one-cycle pulse after each move.
- dead  out  1  sticky collision flag.
- dead_cause  out  2  00 none, 01 wall, 10 body.

## Operation
- Segment i (0 = head) stored in arrays; valid for i < length. Reset/start: segment i = (INIT_X-i, INIT_Y), length = INIT_LEN, direction RIGHT, pending grow 0, queue empty, dead 0, dead_cause 00, tick counter 0, step 0, query_hit 00.
- Reset and start behave identically; start mid-game has priority over every other event in that cycle.
- Tick counter increments only while run=1 and dead=0; on reaching max(tick_period,1)-1 it clears and a move occurs. run=0 freezes the counter.
- Direction queue (2 entries): on dir_valid, request compared to last queued direction (or current if empty); reversal or duplicate is dropped; full queue drops the request. At each move one entry is popped and becomes current before computing next head.
- Next head = head ±1 per direction. wrap_mode=0: if next head on border, dead=1, cause=01, no position change. wrap_mode=1: x=0→GRID_W-2, x=GRID_W-1→1, same for y; never lethal.
- Self collision: next head equal to any segment i in 1..length-2 (tail excluded as it vacates), or 1..length-1 when a growth is applied this move → dead=1, cause=10, no move. Wall check takes precedence.
- Legal move: segments shift i←i-1, head takes next head. If pending>0 and length<MAX_LEN: length+1 (new tail keeps old tail cell), pending-1.
- grow: pending+1, saturating so length+pending ≤ MAX_LEN; at MAX_LEN grow ignored. grow on a move cycle is counted for the next move.
- dead is sticky until rst_n or start; queue and grow still accepted but no moves.
- Query: border cell → 11 (both modes); else head match → 01; else any valid body segment → 10; else 00.

## Timing
- Move decision in the cycle the counter hits terminal count; positions, length, dead, dead_cause update at that edge; step high the following cycle for exactly 1 cycle (also on fatal tick).
- query_hit registered: 1-cycle latency from query_x/query_y, reflects state at the sampling edge.
- dir_valid in the same cycle as a move is enqueued after the pop (affects the next move).
- Reset asynchronous; all outputs take reset values immediately.

## Test plan
- Reset, run=1, tick_period=4: step every 4 cycles; head (10,5)→(11,5)→(12,5), length 5.
- Moving RIGHT, dir_valid LEFT then UP within one tick: LEFT dropped, next move head (x,4); second request DOWN after UP queued is dropped as reversal.
- wrap_mode=0, head (38,5) RIGHT: next tick dead=1, cause=01, head stays (38,5); wrap_mode=1: head becomes (1,5).
- grow ×3 at length 14, MAX_LEN 16: length 15, 16, then stays 16 on later moves.
- Length 5, queue DOWN, LEFT, UP on successive ticks: head re-enters own body → dead=1, cause=10; start clears to initial state.
- query (0,7)→11, (10,5)→01, (9,5)→10, (20,20)→00, each valid one cycle after presentation.
